sap1_loader: RTL and testbench
==============================

SAP1_LOADER -- requirements
Module: sap1_loader

Interface
REQ-001 Parameter WORDS, default 16, number of program bytes written to RAM (1..16).
REQ-002 Parameter CLR_HOLD, default 4, cycles cpu_clr stays high after a good load before release (>=1).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 clr_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load session.
REQ-006 in_data  input  8  program or checksum byte from host.
REQ-007 in_valid  input  1  host byte valid.
REQ-008 in_ready  output  1  loader accepts byte this cycle.
REQ-009 ram_we  output  1  one-cycle write strobe to the CPU's 16x8 RAM.
REQ-010 ram_addr  output  4  RAM write address.
REQ-011 ram_wdata  output  8  RAM write data.
REQ-012 cpu_clr  output  1  active-high clear to the CPU; high holds the CPU in reset.
REQ-013 busy  output  1  session in progress (LOAD or HOLD).
REQ-014 done  output  1  last session succeeded; CPU released.
REQ-015 err  output  1  last session failed its checksum; CPU held.

Function
REQ-016 States SHALL be IDLE, LOAD, HOLD, RUN and ERROR.
REQ-017 A transfer SHALL occur only on a rising edge where in_valid and in_ready are both 1.
REQ-018 in_ready SHALL be 1 only in LOAD. Host data SHALL NOT be consumed in any other state.
REQ-019 IDLE: cpu_clr=1. On start=1, go to LOAD next cycle, clear byte count and running sum, and set busy=1.
REQ-020 LOAD, count<WORDS: each transfer registers ram_we=1, ram_addr=count[3:0] and ram_wdata=in_data for exactly the following cycle. It also adds in_data to an 8-bit running sum (mod 256) and increments count.
REQ-021 ram_we SHALL be 0 in every cycle not directly following a data transfer. Back-to-back transfers SHALL produce back-to-back writes to consecutive addresses.
REQ-022 LOAD, count==WORDS: the next transfer is the checksum byte and SHALL NOT write RAM.
 - checksum byte equals the running sum: go to HOLD.
 - otherwise: go to ERROR.
REQ-023 HOLD: cpu_clr=1 for exactly CLR_HOLD cycles, then RUN.
REQ-024 RUN: cpu_clr=0, done=1, busy=0.
REQ-025 ERROR: cpu_clr=1, err=1, busy=0. No RAM writes.
REQ-026 start SHALL be ignored in LOAD and HOLD.
REQ-027 start in RUN or ERROR SHALL enter LOAD on the next edge, with done=0, err=0 and cpu_clr=1 from that same edge.
REQ-028 Idle gaps (in_valid=0) of any length within LOAD SHALL be tolerated with no state change.
REQ-029 done and err SHALL never be 1 simultaneously.
REQ-030 All outputs SHALL be registered, except in_ready, which is decoded from state.

Reset
REQ-031 clr_n=0 at any time, including mid-LOAD or mid-HOLD, SHALL immediately force:
 - state IDLE;
 - cpu_clr=1;
 - in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0;
 - busy=0, done=0, err=0;
 - count=0, running sum=0.
REQ-032 After clr_n rises, the first start SHALL be honored on the first rising edge at which it is sampled high.

Verification
REQ-033 Reset, then start. Send bytes 0x01..0x10 back-to-back, then checksum 0x88.
 - 16 writes occur to addr 0..15 with data 0x01..0x10.
 - cpu_clr drops 4 cycles after entering HOLD; done=1.
REQ-034 Same stream with checksum 0x89: err=1, done=0 and cpu_clr stays 1; the 16 writes still occur.
REQ-035 Load with in_valid toggled 1/0 every cycle.
 - Writes occur only after valid transfers.
 - Addresses stay consecutive and the result matches REQ-033.
REQ-036 Pull clr_n low after 7 bytes of a session.
 - All outputs are at reset values during the low pulse.
 - A new session from address 0 then completes normally.
REQ-037 Pulse start during LOAD: ignored, with no count change.
REQ-038 Pulse start in RUN: cpu_clr=1 and done=0 on the next edge. A WORDS=4 reload of 0xFF x4 with checksum 0xFC succeeds.

Source files
------------

// File: rtl/sap1_loader.sv
// Program loader for a SAP-1 style CPU: streams WORDS bytes into the 16x8 RAM,
// verifies an 8-bit additive checksum, then releases the CPU from clear.
module sap1_loader #(
    parameter int WORDS    = 16,
    parameter int CLR_HOLD = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       cpu_clr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [4:0] WORDS_C = 5'(WORDS);
    localparam int HW = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(CLR_HOLD - 1);

    function automatic logic [7:0] sum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    state_t        state_r, state_s;
    logic [4:0]    count_r, count_s;
    logic [7:0]    sum_r, sum_s;
    logic [HW-1:0] hold_r, hold_s;
    logic          ram_we_r, ram_we_s;
    logic [3:0]    ram_addr_r, ram_addr_s;
    logic [7:0]    ram_wdata_r, ram_wdata_s;
    logic          cpu_clr_r, cpu_clr_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          err_r, err_s;
    logic          xfer_s;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        sum_s       = sum_r;
        hold_s      = hold_r;
        ram_we_s    = 1'b0;
        ram_addr_s  = ram_addr_r;
        ram_wdata_s = ram_wdata_r;
        xfer_s      = (state_r == ST_LOAD) && in_valid;
        case (state_r)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_s = ST_LOAD;
                    count_s = 5'd0;
                    sum_s   = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (!xfer_s) begin
                    state_s = ST_LOAD;
                end else if (count_r < WORDS_C) begin
                    ram_we_s    = 1'b1;
                    ram_addr_s  = count_r[3:0];
                    ram_wdata_s = in_data;
                    sum_s       = sum_add(sum_r, in_data);
                    count_s     = count_r + 5'd1;
                end else if (in_data == sum_r) begin
                    state_s = ST_HOLD;
                    hold_s  = '0;
                end else begin
                    state_s = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (hold_r == HOLD_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    hold_s = hold_r + HW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Status flags follow the state being entered so they change on the same edge
        cpu_clr_s = (state_s != ST_RUN);
        busy_s    = (state_s == ST_LOAD) || (state_s == ST_HOLD);
        done_s    = (state_s == ST_RUN);
        err_s     = (state_s == ST_ERROR);
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r     <= ST_IDLE;
            count_r     <= 5'd0;
            sum_r       <= 8'd0;
            hold_r      <= '0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= 4'd0;
            ram_wdata_r <= 8'd0;
            cpu_clr_r   <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            sum_r       <= sum_s;
            hold_r      <= hold_s;
            ram_we_r    <= ram_we_s;
            ram_addr_r  <= ram_addr_s;
            ram_wdata_r <= ram_wdata_s;
            cpu_clr_r   <= cpu_clr_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign in_ready  = (state_r == ST_LOAD);
    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign cpu_clr   = cpu_clr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_sap1_loader.sv
// Scoreboard bench for sap1_loader: a WORDS=16 instance for the main scenarios
// and a WORDS=4 instance for the short reload.
module tb_sap1_loader;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sel4 = 1'b0;

    logic       start16, valid16, start4, valid4;
    logic       in_ready16, ram_we16, cpu_clr16, busy16, done16, err16;
    logic [3:0] ram_addr16;
    logic [7:0] ram_wdata16;
    logic       in_ready4, ram_we4, cpu_clr4, busy4, done4, err4;
    logic [3:0] ram_addr4;
    logic [7:0] ram_wdata4;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_w;
    logic [7:0]  pbuf[0:16];

    assign start16 = start & ~sel4;
    assign valid16 = in_valid & ~sel4;
    assign start4  = start & sel4;
    assign valid4  = in_valid & sel4;

    always #5 clk = ~clk;

    sap1_loader #(.WORDS(16), .CLR_HOLD(4)) u_dut16 (
        .clk(clk), .clr_n(clr_n), .start(start16), .in_data(in_data), .in_valid(valid16),
        .in_ready(in_ready16), .ram_we(ram_we16), .ram_addr(ram_addr16), .ram_wdata(ram_wdata16),
        .cpu_clr(cpu_clr16), .busy(busy16), .done(done16), .err(err16)
    );

    sap1_loader #(.WORDS(4), .CLR_HOLD(4)) u_dut4 (
        .clk(clk), .clr_n(clr_n), .start(start4), .in_data(in_data), .in_valid(valid4),
        .in_ready(in_ready4), .ram_we(ram_we4), .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
        .cpu_clr(cpu_clr4), .busy(busy4), .done(done4), .err(err4)
    );

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (ram_we16 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr16_unexpected: addr=%0d data=%h, expected no write", ram_addr16, ram_wdata16);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({ram_addr16, ram_wdata16} !== exp_w) begin
                        errors++;
                        $display("FAIL wr16: addr=%0d data=%h, expected addr=%0d data=%h",
                                 ram_addr16, ram_wdata16, exp_w[11:8], exp_w[7:0]);
                    end
                end
            end
            if (ram_we4 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr4_unexpected: addr=%0d data=%h, expected no write", ram_addr4, ram_wdata4);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({ram_addr4, ram_wdata4} !== exp_w) begin
                        errors++;
                        $display("FAIL wr4: addr=%0d data=%h, expected addr=%0d data=%h",
                                 ram_addr4, ram_wdata4, exp_w[11:8], exp_w[7:0]);
                    end
                end
            end
            checks++;
            if ((done16 & err16) === 1'b1 || (done4 & err4) === 1'b1) begin
                errors++;
                $display("FAIL done_err_excl: done16/err16=%b%b done4/err4=%b%b, expected never 11",
                         done16, err16, done4, err4);
            end
        end
    endtask

    task automatic fill_ramp(input logic [7:0] chk);
        for (int i = 0; i < 16; i++) pbuf[i] = 8'(i + 1);
        pbuf[16] = chk;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Send pbuf[lo..hi-1]; indices below words are program bytes and expect a write
    task automatic send_bytes(input int lo, input int hi, input bit toggle, input int words);
        for (int i = lo; i < hi; i++) begin
            if (toggle && i > lo) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (i < words) exp_q.push_back({4'(i), pbuf[i]});
            in_data  = pbuf[i];
            in_valid = 1'b1;
            checks++;
            if ((sel4 ? in_ready4 : in_ready16) !== 1'b1) begin
                errors++;
                $display("FAIL in_ready: got 0 before byte %0d, expected 1", i);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 clr_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({in_ready16, ram_we16, ram_addr16, ram_wdata16, cpu_clr16, busy16, done16, err16} !==
            {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset16: rdy=%b we=%b a=%0d d=%h clr=%b busy=%b done=%b err=%b, expected 0 0 0 00 1 0 0 0",
                     in_ready16, ram_we16, ram_addr16, ram_wdata16, cpu_clr16, busy16, done16, err16);
        end
        checks++;
        if ({cpu_clr4, busy4, done4, err4, in_ready4} !== 5'b10000) begin
            errors++;
            $display("FAIL reset4: clr/busy/done/err/rdy=%b, expected 10000", {cpu_clr4, busy4, done4, err4, in_ready4});
        end
        clr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_good();
        fill_ramp(8'h88);
        do_start();
        checks++;
        if ({busy16, cpu_clr16, in_ready16} !== 3'b111) begin
            errors++;
            $display("FAIL start_load: busy/clr/rdy=%b, expected 111", {busy16, cpu_clr16, in_ready16});
        end
        send_bytes(0, 17, 1'b0, 16);
        checks++;
        if ({busy16, cpu_clr16, in_ready16, done16} !== 4'b1100) begin
            errors++;
            $display("FAIL hold_entry: busy/clr/rdy/done=%b, expected 1100", {busy16, cpu_clr16, in_ready16, done16});
        end
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (cpu_clr16 !== 1'b1) begin
                errors++;
                $display("FAIL hold_clr: cpu_clr=%b at hold cycle %0d, expected 1", cpu_clr16, c);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({cpu_clr16, done16, busy16, err16} !== 4'b0100) begin
            errors++;
            $display("FAIL run_good: clr/done/busy/err=%b, expected 0100", {cpu_clr16, done16, busy16, err16});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL writes_good: %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        fill_ramp(8'h89);
        do_start();
        checks++;
        if ({cpu_clr16, done16, busy16} !== 3'b101) begin
            errors++;
            $display("FAIL restart_run: clr/done/busy=%b, expected 101", {cpu_clr16, done16, busy16});
        end
        send_bytes(0, 17, 1'b0, 16);
        checks++;
        if ({err16, done16, cpu_clr16, busy16} !== 4'b1010) begin
            errors++;
            $display("FAIL err_state: err/done/clr/busy=%b, expected 1010", {err16, done16, cpu_clr16, busy16});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL writes_bad: %0d writes missing, expected 0", exp_q.size());
        end
        // Host bytes offered in ERROR must be neither accepted nor written
        in_data  = 8'h5A;
        in_valid = 1'b1;
        checks++;
        if (in_ready16 !== 1'b0) begin
            errors++;
            $display("FAIL err_ready: in_ready=%b, expected 0", in_ready16);
        end
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if ({err16, cpu_clr16, done16} !== 3'b110) begin
            errors++;
            $display("FAIL err_stay: err/clr/done=%b, expected 110", {err16, cpu_clr16, done16});
        end
    endtask

    task automatic test_toggle_valid();
        fill_ramp(8'h88);
        do_start();
        checks++;
        if ({err16, busy16, cpu_clr16} !== 3'b011) begin
            errors++;
            $display("FAIL restart_err: err/busy/clr=%b, expected 011", {err16, busy16, cpu_clr16});
        end
        send_bytes(0, 17, 1'b1, 16);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({done16, cpu_clr16, err16, busy16} !== 4'b1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL toggle_result: done/clr/err/busy=%b pending=%0d, expected 1000 pending=0",
                     {done16, cpu_clr16, err16, busy16}, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        fill_ramp(8'h88);
        do_start();
        send_bytes(0, 7, 1'b0, 16);
        @(posedge clk); #1;
        clr_n = 1'b0;
        #1;
        checks++;
        if ({in_ready16, ram_we16, ram_addr16, ram_wdata16, cpu_clr16, busy16, done16, err16} !==
            {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b we=%b a=%0d d=%h clr=%b busy=%b done=%b err=%b, expected 0 0 0 00 1 0 0 0",
                     in_ready16, ram_we16, ram_addr16, ram_wdata16, cpu_clr16, busy16, done16, err16);
        end
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy16, in_ready16, cpu_clr16} !== 3'b001) begin
            errors++;
            $display("FAIL reset_hold_start: busy/rdy/clr=%b, expected 001", {busy16, in_ready16, cpu_clr16});
        end
        start = 1'b0;
        clr_n = 1'b1;
        do_start();
        checks++;
        if ({busy16, in_ready16} !== 2'b11) begin
            errors++;
            $display("FAIL first_start: busy/rdy=%b, expected 11", {busy16, in_ready16});
        end
        send_bytes(0, 17, 1'b0, 16);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({done16, cpu_clr16, err16} !== 3'b100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reload_after_reset: done/clr/err=%b pending=%0d, expected 100 pending=0",
                     {done16, cpu_clr16, err16}, exp_q.size());
        end
    endtask

    task automatic test_start_in_load();
        fill_ramp(8'h88);
        do_start();
        send_bytes(0, 5, 1'b0, 16);
        do_start();
        checks++;
        if ({busy16, in_ready16, ram_we16} !== 3'b110) begin
            errors++;
            $display("FAIL start_in_load: busy/rdy/we=%b, expected 110", {busy16, in_ready16, ram_we16});
        end
        send_bytes(5, 17, 1'b0, 16);
        do_start();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done16, busy16, cpu_clr16} !== 3'b100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL start_in_hold: done/busy/clr=%b pending=%0d, expected 100 pending=0",
                     {done16, busy16, cpu_clr16}, exp_q.size());
        end
    endtask

    task automatic test_start_in_run();
        do_start();
        checks++;
        if ({cpu_clr16, done16, busy16} !== 3'b101) begin
            errors++;
            $display("FAIL run_restart16: clr/done/busy=%b, expected 101", {cpu_clr16, done16, busy16});
        end
    endtask

    task automatic test_reload_words4();
        sel4 = 1'b1;
        pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33; pbuf[3] = 8'h44; pbuf[4] = 8'hAA;
        do_start();
        send_bytes(0, 5, 1'b0, 4);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({done4, cpu_clr4, err4} !== 3'b100) begin
            errors++;
            $display("FAIL w4_first: done/clr/err=%b, expected 100", {done4, cpu_clr4, err4});
        end
        do_start();
        checks++;
        if ({cpu_clr4, done4, busy4} !== 3'b101) begin
            errors++;
            $display("FAIL w4_restart: clr/done/busy=%b, expected 101", {cpu_clr4, done4, busy4});
        end
        for (int i = 0; i < 4; i++) pbuf[i] = 8'hFF;
        pbuf[4] = 8'hFC;
        send_bytes(0, 5, 1'b0, 4);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({done4, cpu_clr4, err4, busy4} !== 4'b1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL w4_reload: done/clr/err/busy=%b pending=%0d, expected 1000 pending=0",
                     {done4, cpu_clr4, err4, busy4}, exp_q.size());
        end
        checks++;
        if (busy16 !== 1'b1 || ram_we16 !== 1'b0) begin
            errors++;
            $display("FAIL w16_isolated: busy16=%b we16=%b, expected 1 0", busy16, ram_we16);
        end
        sel4 = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_good();
        test_bad_checksum();
        test_toggle_valid();
        test_reset_mid_load();
        test_start_in_load();
        test_start_in_run();
        test_reload_words4();
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
